// File: rtl/sargantana_icache_pkg.sv
// Shared types and default geometry for the icache refill path.
package sargantana_icache_pkg;

  localparam int unsigned IC_LINE_WIDTH = 512;
  localparam int unsigned IC_BEAT_WIDTH = 128;

  // Keeps a one-beat line from collapsing the counter to zero width.
  function automatic int unsigned cnt_bits(input int unsigned n_beats);
    return (n_beats > 1) ? $clog2(n_beats) : 1;
  endfunction

  localparam int unsigned N_BEATS     = IC_LINE_WIDTH / IC_BEAT_WIDTH;
  localparam int unsigned CNT_BITS    = cnt_bits(N_BEATS);
  localparam int unsigned OFFSET_BITS = $clog2(IC_LINE_WIDTH / 8);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StDrain,
    StDeliver
  } ifill_state_t;

endpackage

// File: rtl/sargantana_icache_rr_victim.sv
// One-hot round-robin victim way pointer; rotates left by one on each advance.
module sargantana_icache_rr_victim #(
  parameter int unsigned NWay = 4
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            advance_i,
  output logic [NWay-1:0] way_o
);

  logic [NWay-1:0] way_d, way_q;

  always_comb begin
    way_d = way_q;
    if (advance_i) begin
      way_d = {way_q[NWay-2:0], way_q[NWay-1]};
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      way_q <= NWay'(1);
    end else begin
      way_q <= way_d;
    end
  end

  assign way_o = way_q;

endmodule

// File: rtl/sargantana_icache_ifill_ctrl.sv
// Icache refill sequencer: one line-aligned L2 read per miss, beat assembly,
// kill draining and a one-cycle write strobe with a round-robin victim way.
module sargantana_icache_ifill_ctrl
  import sargantana_icache_pkg::*;
#(
  parameter int unsigned ICACHE_N_WAY = 4,
  parameter int unsigned LINE_WIDTH   = 512,
  parameter int unsigned BEAT_WIDTH   = 128,
  parameter int unsigned ADDR_WIDTH   = 40
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    ifill_req_valid_i,
  input  logic [ADDR_WIDTH-1:0]   ifill_req_paddr_i,
  input  logic                    kill_i,
  output logic                    l2_req_valid_o,
  input  logic                    l2_req_ready_i,
  output logic [ADDR_WIDTH-1:0]   l2_req_addr_o,
  input  logic                    l2_resp_valid_i,
  input  logic [BEAT_WIDTH-1:0]   l2_resp_data_i,
  output logic                    ifill_sent_ack_o,
  output logic                    ifill_resp_valid_o,
  output logic                    valid_ifill_resp_o,
  output logic [LINE_WIDTH-1:0]   ifill_line_o,
  output logic [ICACHE_N_WAY-1:0] ifill_way_o
);

  localparam int unsigned NBeats     = LINE_WIDTH / BEAT_WIDTH;
  localparam int unsigned CntBits    = cnt_bits(NBeats);
  localparam int unsigned OffsetBits = $clog2(LINE_WIDTH / 8);
  localparam logic [CntBits-1:0] LastBeat = CntBits'(NBeats - 1);

  ifill_state_t            state_d, state_q;
  logic [CntBits-1:0]      cnt_d, cnt_q;
  logic [LINE_WIDTH-1:0]   line_d, line_q;
  logic [ADDR_WIDTH-1:0]   addr_d, addr_q;
  logic                    killed_d, killed_q;
  logic                    replay_d, replay_q;
  logic                    victim_advance;
  logic [ICACHE_N_WAY-1:0] victim_way;
  logic                    last_beat;
  logic                    start_req;

  assign last_beat = l2_resp_valid_i && (cnt_q == LastBeat);
  assign start_req = (state_q == StIdle) && ifill_req_valid_i && !kill_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_req) state_d = StReq;
      end
      StReq: begin
        if (l2_req_ready_i) state_d = (killed_q || kill_i) ? StDrain : StWait;
      end
      StWait: begin
        // A kill on the final beat drops the line without a write.
        if (last_beat) begin
          state_d = kill_i ? StIdle : StDeliver;
        end else if (kill_i) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (last_beat) state_d = StIdle;
      end
      StDeliver: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    l2_req_valid_o     = 1'b0;
    ifill_sent_ack_o   = 1'b0;
    ifill_resp_valid_o = 1'b0;
    ifill_way_o        = '0;
    victim_advance     = 1'b0;
    unique case (state_q)
      StReq: begin
        l2_req_valid_o   = 1'b1;
        ifill_sent_ack_o = 1'b1;
      end
      StWait, StDrain: ifill_sent_ack_o = 1'b1;
      StDeliver: begin
        ifill_resp_valid_o = 1'b1;
        ifill_way_o        = victim_way;
        victim_advance     = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    addr_d   = addr_q;
    killed_d = killed_q;
    cnt_d    = cnt_q;
    line_d   = line_q;
    replay_d = (state_q == StDeliver);
    if (start_req) begin
      addr_d   = {ifill_req_paddr_i[ADDR_WIDTH-1:OffsetBits], {OffsetBits{1'b0}}};
      killed_d = 1'b0;
    end
    if (state_q == StReq && kill_i) begin
      killed_d = 1'b1;
    end
    // Beats outside WAIT/DRAIN are protocol errors and leave the counter alone.
    if (l2_resp_valid_i && (state_q == StWait || state_q == StDrain)) begin
      cnt_d = (cnt_q == LastBeat) ? '0 : cnt_q + CntBits'(1);
    end
    if (l2_resp_valid_i && state_q == StWait) begin
      line_d[cnt_q*BEAT_WIDTH +: BEAT_WIDTH] = l2_resp_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q    <= '0;
      line_q   <= '0;
      addr_q   <= '0;
      killed_q <= 1'b0;
      replay_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      line_q   <= line_d;
      addr_q   <= addr_d;
      killed_q <= killed_d;
      replay_q <= replay_d;
    end
  end

  sargantana_icache_rr_victim #(
    .NWay(ICACHE_N_WAY)
  ) u_victim (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .advance_i(victim_advance),
    .way_o    (victim_way)
  );

  assign l2_req_addr_o      = addr_q;
  assign ifill_line_o       = line_q;
  assign valid_ifill_resp_o = replay_q;

endmodule

// File: tb/tb_sargantana_icache_ifill_ctrl.sv
// Bench for the icache refill sequencer: transaction-level model plus directed and random traffic.
module tb_sargantana_icache_ifill_ctrl;

  localparam int NW = 4;
  localparam int LW = 512;
  localparam int BW = 128;
  localparam int AW = 40;
  localparam int NB = LW / BW;

  logic          clk = 1'b0;
  logic          rstn;
  logic          req_valid;
  logic [AW-1:0] req_paddr;
  logic          kill;
  logic          l2_req_valid;
  logic          l2_req_ready;
  logic [AW-1:0] l2_req_addr;
  logic          l2_resp_valid;
  logic [BW-1:0] l2_resp_data;
  logic          sent_ack;
  logic          resp_valid;
  logic          replay;
  logic [LW-1:0] line;
  logic [NW-1:0] way;

  always #5 clk = ~clk;

  sargantana_icache_ifill_ctrl dut (
    .clk_i             (clk),
    .rstn_i            (rstn),
    .ifill_req_valid_i (req_valid),
    .ifill_req_paddr_i (req_paddr),
    .kill_i            (kill),
    .l2_req_valid_o    (l2_req_valid),
    .l2_req_ready_i    (l2_req_ready),
    .l2_req_addr_o     (l2_req_addr),
    .l2_resp_valid_i   (l2_resp_valid),
    .l2_resp_data_i    (l2_resp_data),
    .ifill_sent_ack_o  (sent_ack),
    .ifill_resp_valid_o(resp_valid),
    .valid_ifill_resp_o(replay),
    .ifill_line_o      (line),
    .ifill_way_o       (way)
  );

  // Transaction-level model: a pending request, beats still owed by L2,
  // a discard flag, a delivery slot and the victim index.
  bit            m_req_pend;
  int            m_left;
  int            m_got;
  bit            m_discard;
  bit            m_deliver;
  bit            m_replay;
  int            m_victim;
  logic [AW-1:0] m_addr;
  logic [BW-1:0] m_beat [NB];

  int vecs;
  int errs;
  int dut_hs;

  task automatic model_reset();
    m_req_pend = 0;
    m_left     = 0;
    m_got      = 0;
    m_discard  = 0;
    m_deliver  = 0;
    m_replay   = 0;
    m_victim   = 0;
    m_addr     = '0;
    for (int i = 0; i < NB; i++) m_beat[i] = '0;
  endtask

  task automatic model_step();
    bit next_replay;
    if (!rstn) begin
      model_reset();
      return;
    end
    next_replay = m_deliver;
    if (m_deliver) begin
      m_victim  = (m_victim + 1) % NW;
      m_deliver = 0;
    end else if (m_req_pend) begin
      if (kill) m_discard = 1;
      if (l2_req_ready) begin
        m_req_pend = 0;
        m_left     = NB;
        m_got      = 0;
      end
    end else if (m_left > 0) begin
      if (l2_resp_valid) begin
        if (!m_discard) m_beat[m_got] = l2_resp_data;
        m_got++;
        m_left--;
        if (m_left == 0 && !m_discard && !kill) m_deliver = 1;
      end
      if (kill) m_discard = 1;
    end else if (req_valid && !kill) begin
      m_req_pend = 1;
      m_discard  = 0;
      m_addr     = req_paddr & ~(AW'(LW / 8 - 1));
    end
    m_replay = next_replay;
  endtask

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic compare();
    logic [LW-1:0] exp_way;
    exp_way = m_deliver ? (LW'(1) << m_victim) : '0;
    chk("l2_req_valid", LW'(l2_req_valid), LW'(m_req_pend));
    chk("sent_ack", LW'(sent_ack), LW'(m_req_pend || m_left > 0));
    chk("resp_valid", LW'(resp_valid), LW'(m_deliver));
    chk("way", LW'(way), exp_way);
    chk("replay", LW'(replay), LW'(m_replay));
    if (m_req_pend) chk("l2_req_addr", LW'(l2_req_addr), LW'(m_addr));
    if (m_deliver) chk("line", line, {m_beat[3], m_beat[2], m_beat[1], m_beat[0]});
  endtask

  task automatic tick();
    if (l2_req_valid && l2_req_ready) dut_hs++;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic quiet();
    req_valid     = 1'b0;
    kill          = 1'b0;
    l2_resp_valid = 1'b0;
  endtask

  function automatic logic [BW-1:0] rnd_beat();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Clean refill; exp_way < 0 means rely on the model only.
  task automatic refill(input logic [AW-1:0] pa, input int exp_way);
    quiet();
    req_valid    = 1'b1;
    req_paddr    = pa;
    l2_req_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    for (int i = 0; i < NB; i++) begin
      l2_resp_valid = 1'b1;
      l2_resp_data  = rnd_beat();
      tick();
    end
    l2_resp_valid = 1'b0;
    chk("refill_strobe", LW'(resp_valid), LW'(1));
    if (exp_way >= 0) chk("refill_way", LW'(way), LW'(exp_way));
    tick();
  endtask

  task automatic do_reset();
    quiet();
    rstn = 1'b0;
    model_reset();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  logic [BW-1:0] ba, bb, bc, bd;

  initial begin
    vecs         = 0;
    errs         = 0;
    dut_hs       = 0;
    rstn         = 1'b0;
    req_paddr    = '0;
    l2_req_ready = 1'b0;
    l2_resp_data = '0;
    quiet();
    model_reset();
    repeat (2) @(negedge clk);
    compare();
    chk("rst_line", line, '0);
    chk("rst_sent_ack", LW'(sent_ack), '0);
    chk("rst_way", LW'(way), '0);
    rstn = 1'b1;
    tick();

    // Basic refill with literal latency and line ordering
    ba = {4{32'hAAAA_0001}};
    bb = {4{32'hBBBB_0002}};
    bc = {4{32'hCCCC_0003}};
    bd = {4{32'hDDDD_0004}};
    req_valid    = 1'b1;
    req_paddr    = 40'h80_0000_1234;
    l2_req_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("t1_addr", LW'(l2_req_addr), LW'(40'h80_0000_1200));
    chk("t1_req_valid", LW'(l2_req_valid), LW'(1));
    tick();
    l2_resp_valid = 1'b1;
    l2_resp_data = ba; tick();
    l2_resp_data = bb; tick();
    l2_resp_data = bc; tick();
    l2_resp_data = bd; tick();
    l2_resp_valid = 1'b0;
    chk("t1_strobe_c6", LW'(resp_valid), LW'(1));
    chk("t1_line", line, {bd, bc, bb, ba});
    chk("t1_way", LW'(way), LW'(4'b0001));
    tick();
    chk("t1_replay_c7", LW'(replay), LW'(1));
    chk("t1_strobe_off", LW'(resp_valid), '0);

    // Kill while the request waits for ready: drained, never delivered
    l2_req_ready = 1'b0;
    req_valid    = 1'b1;
    req_paddr    = 40'h12_3456_789A;
    tick();
    req_valid = 1'b0;
    kill = 1'b1; tick();
    kill = 1'b0; tick(); tick(); tick();
    chk("t2_req_held", LW'(l2_req_valid), LW'(1));
    l2_req_ready = 1'b1;
    tick();
    for (int i = 0; i < NB; i++) begin
      l2_resp_valid = 1'b1;
      l2_resp_data  = rnd_beat();
      tick();
    end
    l2_resp_valid = 1'b0;
    chk("t2_ack_fall", LW'(sent_ack), '0);
    chk("t2_no_strobe", LW'(resp_valid), '0);
    tick();

    // Kill on the final beat: dropped, victim pointer untouched
    req_valid = 1'b1;
    req_paddr = 40'h00_0000_0FC0;
    tick();
    req_valid = 1'b0;
    tick();
    for (int i = 0; i < NB; i++) begin
      l2_resp_valid = 1'b1;
      l2_resp_data  = rnd_beat();
      kill          = (i == NB - 1);
      tick();
    end
    quiet();
    chk("t3_no_strobe", LW'(resp_valid), '0);
    chk("t3_idle", LW'(sent_ack), '0);
    refill(40'h00_0000_0040, 4'b0010);

    // Round-robin victim across five refills from reset
    do_reset();
    refill(40'h01_0000_0000, 4'b0001);
    refill(40'h01_0000_0040, 4'b0010);
    refill(40'h01_0000_0080, 4'b0100);
    refill(40'h01_0000_00C0, 4'b1000);
    refill(40'h01_0000_0100, 4'b0001);

    // Request during WAIT is ignored
    dut_hs    = 0;
    req_valid = 1'b1;
    req_paddr = 40'h02_0000_0000;
    tick();
    req_valid = 1'b0;
    tick();
    for (int i = 0; i < NB; i++) begin
      l2_resp_valid = 1'b1;
      l2_resp_data  = rnd_beat();
      req_valid     = (i == 1);
      req_paddr     = 40'h03_0000_0000;
      tick();
    end
    quiet();
    tick();
    tick();
    chk("t5_one_request", LW'(dut_hs), LW'(1));

    // Reset during WAIT after two beats
    req_valid = 1'b1;
    req_paddr = 40'h04_0000_0000;
    tick();
    req_valid = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      l2_resp_valid = 1'b1;
      l2_resp_data  = rnd_beat();
      tick();
    end
    quiet();
    rstn = 1'b0;
    model_reset();
    #1;
    chk("t6_req_valid", LW'(l2_req_valid), '0);
    chk("t6_sent_ack", LW'(sent_ack), '0);
    chk("t6_line", line, '0);
    chk("t6_addr", LW'(l2_req_addr), '0);
    tick();
    rstn = 1'b1;
    tick();
    refill(40'h05_0000_0000, 4'b0001);

    // Randomized traffic, protocol-error beats included
    for (int c = 0; c < 600; c++) begin
      req_valid     = ($urandom_range(3) == 0);
      req_paddr     = {$urandom, $urandom};
      kill          = ($urandom_range(15) == 0);
      l2_req_ready  = ($urandom_range(1) == 1);
      l2_resp_valid = ($urandom_range(2) != 0);
      l2_resp_data  = rnd_beat();
      tick();
    end
    quiet();
    l2_req_ready  = 1'b1;
    l2_resp_valid = 1'b1;
    repeat (8) tick();
    quiet();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
